dcache_wb_fifo: RTL and testbench
=================================

# dcache_wb_fifo

Write-back buffer sitting directly downstream of the DCache. It accepts dirty 256-bit lines evicted by the cache, holds them in a small fully associative FIFO, and drains them to memory one line at a time over the cache's `mem_wen`/`mem_bvalid` write handshake. While a line waits it can be looked up and word-updated by the cache, so a read or write that misses the cache but hits a pending victim is served without a memory round trip.

## Interface
- `DEPTH`, 4: number of line entries; power of two, ≥2.
- `LINE_W`, 256: line width in bits (8 × 32-bit words).
- `ADDR_W`, 32: address width.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `wb_req_i` in 1: push an evicted dirty line.
- `wb_addr_i` in ADDR_W: victim line address; bits [4:0] ignored and treated as 0.
- `wb_data_i` in LINE_W: victim line data.
- `full_o` out 1: all entries valid.
- `empty_o` out 1: no entries valid.
- `lookup_addr_i` in ADDR_W: cache miss address to search.
- `lookup_hit_o` out 1: combinational; a valid entry matches `lookup_addr_i[31:5]`.
- `lookup_data_o` out LINE_W: data of the matching entry; 0 when no hit.
- `upd_en_i` in 1: overwrite one word of a matching entry.
- `upd_addr_i` in ADDR_W: update address; [31:5] selects the line, [4:2] the word.
- `upd_wdata_i` in 32: word to write.
- `mem_wen_o` out 1: write request to memory.
- `mem_awaddr_o` out ADDR_W: head line address, with [4:0] = 0.
- `mem_wdata_o` out LINE_W: head line data, driven live from storage.
- `mem_bvalid_i` in 1: memory write response; one pulse per completed line.

## Operation
- Storage: per entry `valid`, `tag[31:5]`, `data`, `resend`; plus `head`, `tail`, `count` (0..DEPTH).
- Push, accepted at the clock edge when `wb_req_i` is high:
  - Merge: if the tag matches a valid entry, that entry's data is overwritten. `count` is unchanged, and the merge is accepted even when the FIFO is full.
  - Allocate: otherwise, if `!full_o`, write the line at `tail`, set `valid`, advance `tail` (wrap modulo DEPTH), `count+1`.
  - Drop: otherwise the push is dropped. The cache must not push while `full_o` is high without a match.
- Update (`upd_en_i`): on a tag match, word [4:2] of that entry is replaced. No match means no effect. If a push and an update target the same line in the same cycle, the push data is written first and the update word is applied on top.
- Drain FSM:
  - IDLE: if `count != 0`, go to BUSY.
  - BUSY: `mem_wen_o` = 1, with address and data taken from `head`.
  - On `mem_bvalid_i` with `resend` = 0: clear `valid[head]`, advance `head`, `count-1`, go to IDLE.
  - On `mem_bvalid_i` with `resend` = 1: clear `resend`, keep the entry, go to IDLE, which re-sends the line.
- `resend` is set when a merge or an update hits the `head` entry while in BUSY. This prevents losing a word modified after the memory side may have latched the line.
- At most one entry ever matches a tag, guaranteed by the merge rule.
- Lookups reflect state before the edge. An entry popped at an edge still hits during that cycle.

## Timing
- Reset values:
  - State IDLE; all `valid`/`resend` cleared; pointers and `count` 0.
  - `mem_wen_o` = 0, `full_o` = 0, `empty_o` = 1, `lookup_hit_o` = 0, `lookup_data_o` = 0.
  - `mem_awaddr_o`/`mem_wdata_o` = 0 while empty.
- Reset mid-drain abandons the transfer and discards all entries.
- A pushed line is visible to lookup in the cycle after its push edge.
- `mem_wen_o` rises one cycle after `count` becomes nonzero. Push at edge N gives `mem_wen_o` high after edge N+1.
- `mem_wen_o` stays high until `mem_bvalid_i` is sampled. It is then low for exactly one cycle before the next line (minimum 2 cycles per line plus memory latency).
- `mem_bvalid_i` outside BUSY is ignored.
- Push and pop in the same edge at `count == DEPTH`: `full_o` is evaluated before the edge, so a non-matching push is still dropped.
- Push and pop in the same edge otherwise: both take effect and `count` is unchanged.
- `full_o`/`empty_o` are decoded from the registered `count`.

## Configuration
- `WB_FIFO_FORWARD_EN` defined: lookup and update logic are present as described above.
- `WB_FIFO_FORWARD_EN` undefined:
  - `lookup_hit_o` = 0 and `lookup_data_o` = 0 constantly.
  - `upd_en_i` is ignored and `resend` is only set by a push merge.
  - The cache must stall a miss until `empty_o`. Push merge and drain are unchanged.

## Test plan
- Reset, then push addr 32'h24687570 with data 256'h12345678_91023456_78910234_56789102_34567891_02345678_91023456_78910234. Required: `mem_wen_o` high 2 edges after the push, `mem_awaddr_o` = 32'h24687560, `mem_wdata_o` equal to the pushed data; `mem_bvalid_i` pulse leaves `empty_o` = 1.
- Same line pending, lookup 32'h24687570. Required: `lookup_hit_o` = 1 with identical data. Lookup 32'h59687570 gives `lookup_hit_o` = 0 and `lookup_data_o` = 0.
- Line in BUSY, update 32'h24687570 with 32'h22222222, then `mem_bvalid_i`. Required: the entry is re-sent with `mem_wdata_o` = 256'h12345678_91023456_78910234_22222222_34567891_02345678_91023456_78910234, then popped on the second `mem_bvalid_i`.
- Hold `mem_bvalid_i` low and push 4 distinct lines (0x100, 0x200, 0x300, 0x400). Required: `full_o` = 1, a 5th push at 0x500 is dropped, and a push to 0x300 merges its data. Drain order on the bus is 0x100, 0x200, 0x300, 0x400.
- Full FIFO: push 0x500 in the same cycle as `mem_bvalid_i`. Required: the push is dropped and `count` = 3.
- Assert `rst` low while `mem_wen_o` = 1. Required: `mem_wen_o` drops immediately and `empty_o` = 1.

Source files
------------

// File: rtl/dcache_wb_fifo_if.sv
// ---------------------------------------------------------------------------
// dcache_wb_fifo_if
//
// Purpose: bundles every handshake/bus signal between the DCache, the
// write-back buffer and the memory write port, so the buffer has a compact
// port list. Signal names keep the _i/_o suffixes as seen from the buffer.
//
// Port summary (from the buffer's point of view, i.e. modport slave):
//   push side   : wb_req_i, wb_addr_i, wb_data_i -> full_o, empty_o
//   lookup side : lookup_addr_i -> lookup_hit_o, lookup_data_o
//   update side : upd_en_i, upd_addr_i, upd_wdata_i
//   memory side : mem_wen_o, mem_awaddr_o, mem_wdata_o <- mem_bvalid_i
//
// modport master is the environment (cache + memory), modport slave is the
// buffer itself.
// ---------------------------------------------------------------------------
interface dcache_wb_fifo_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              wb_req_i;
    logic [ADDR_W-1:0] wb_addr_i;
    logic [LINE_W-1:0] wb_data_i;
    logic              full_o;
    logic              empty_o;

    logic [ADDR_W-1:0] lookup_addr_i;
    logic              lookup_hit_o;
    logic [LINE_W-1:0] lookup_data_o;

    logic              upd_en_i;
    logic [ADDR_W-1:0] upd_addr_i;
    logic [31:0]       upd_wdata_i;

    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_awaddr_o;
    logic [LINE_W-1:0] mem_wdata_o;
    logic              mem_bvalid_i;

    // The cache and the memory model drive the buffer's inputs.
    modport master (
        output wb_req_i, wb_addr_i, wb_data_i,
        output lookup_addr_i,
        output upd_en_i, upd_addr_i, upd_wdata_i,
        output mem_bvalid_i,
        input  full_o, empty_o,
        input  lookup_hit_o, lookup_data_o,
        input  mem_wen_o, mem_awaddr_o, mem_wdata_o
    );

    // The write-back buffer itself.
    modport slave (
        input  wb_req_i, wb_addr_i, wb_data_i,
        input  lookup_addr_i,
        input  upd_en_i, upd_addr_i, upd_wdata_i,
        input  mem_bvalid_i,
        output full_o, empty_o,
        output lookup_hit_o, lookup_data_o,
        output mem_wen_o, mem_awaddr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_wb_fifo.sv
// ---------------------------------------------------------------------------
// dcache_wb_fifo
//
// Purpose: write-back buffer downstream of the DCache. Dirty victim lines are
// pushed into a small fully associative FIFO and drained to memory one line
// at a time. Pending lines can be looked up and word-updated by the cache so
// a miss that hits a waiting victim needs no memory round trip.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset
//   bus  - dcache_wb_fifo_if.slave: push, lookup, update and memory write
//          handshake signals (see the interface file)
//
// Configuration macro: WB_FIFO_FORWARD_EN
//   defined   - lookup and word-update logic present
//   undefined - lookup outputs tied to 0, updates ignored; push merge and
//               drain behave identically
// ---------------------------------------------------------------------------
module dcache_wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input logic             clk,
    input logic             rst,
    dcache_wb_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } drain_state_t;

    drain_state_t state_q, state_d;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  resend_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              empty;
    logic              busy;
    logic [TAG_W-1:0]  wb_tag;
    logic              push_hit;
    logic [PTR_W-1:0]  push_idx;
    logic              push_merge;
    logic              push_alloc;
    logic              bresp;
    logic              pop;
    logic              resend_clr;
    logic              resend_set;
    logic              upd_do;
    logic [PTR_W-1:0]  upd_idx;
    logic [2:0]        upd_word;
    logic              unused_low_bits;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign busy   = (state_q == BUSY);
    assign wb_tag = bus.wb_addr_i[ADDR_W-1:5];

    assign unused_low_bits = ^bus.wb_addr_i[4:0];

    // Search the pending entries for the pushed victim's tag. The merge rule
    // guarantees at most one valid entry can ever match.
    always_comb begin
        push_hit = 1'b0;
        push_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == wb_tag)) begin
                push_hit = 1'b1;
                push_idx = PTR_W'(i);
            end
        end
    end

    // A matching push merges even when full; a new line needs a free slot.
    assign push_merge = bus.wb_req_i & push_hit;
    assign push_alloc = bus.wb_req_i & ~push_hit & ~full;

    // A write response only counts while a line is on the bus. If the head
    // was modified during the transfer, the line is kept and sent again.
    assign bresp      = busy & bus.mem_bvalid_i;
    assign pop        = bresp & ~resend_q[head_q];
    assign resend_clr = bresp & resend_q[head_q];

`ifdef WB_FIFO_FORWARD_EN
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              unused_fwd_bits;

    assign upd_tag  = bus.upd_addr_i[ADDR_W-1:5];
    assign upd_word = bus.upd_addr_i[4:2];

    assign unused_fwd_bits = ^{bus.lookup_addr_i[4:0], bus.upd_addr_i[1:0]};

    // Lookup sees the state before the edge, so a line popped at this edge
    // still hits for the whole cycle. Data is zero on a miss.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.lookup_addr_i[ADDR_W-1:5])) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[i];
            end
        end
    end

    // Update target: an existing entry, or the line being allocated in the
    // same cycle, so that the word lands on top of the freshly pushed data.
    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == upd_tag)) begin
                upd_hit = 1'b1;
                upd_idx = PTR_W'(i);
            end
        end
        if (!upd_hit && push_alloc && (wb_tag == upd_tag)) begin
            upd_hit = 1'b1;
            upd_idx = tail_q;
        end
    end

    assign upd_do            = bus.upd_en_i & upd_hit;
    assign bus.lookup_hit_o  = lookup_hit;
    assign bus.lookup_data_o = lookup_data;
`else
    logic unused_fwd_bits;

    assign unused_fwd_bits   = ^{bus.lookup_addr_i, bus.upd_en_i, bus.upd_addr_i};
    assign upd_do            = 1'b0;
    assign upd_idx           = '0;
    assign upd_word          = '0;
    assign bus.lookup_hit_o  = 1'b0;
    assign bus.lookup_data_o = '0;
`endif

    // Touching the head while it is on the bus means memory may already
    // have latched the old copy, so mark it for a second transfer.
    assign resend_set = busy & ((push_merge & (push_idx == head_q)) |
                                (upd_do & (upd_idx == head_q)));

    // Drain FSM state register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM next state: leave IDLE whenever something is pending, and
    // return to IDLE on every response so each line has one idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = BUSY;
            BUSY:    if (bus.mem_bvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Entry storage and pointers. Order matters: push data is written first
    // so an update to the same line overrides one word of it, and a new
    // resend request wins over the clear from a completing transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            resend_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push_alloc) begin
                tag_q[tail_q]    <= wb_tag;
                data_q[tail_q]   <= bus.wb_data_i;
                valid_q[tail_q]  <= 1'b1;
                resend_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + 1'b1;
            end
            if (push_merge) begin
                data_q[push_idx] <= bus.wb_data_i;
            end
            if (upd_do) begin
                data_q[upd_idx][{upd_word, 5'b0} +: 32] <= bus.upd_wdata_i;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (resend_clr) begin
                resend_q[head_q] <= 1'b0;
            end
            if (resend_set) begin
                resend_q[head_q] <= 1'b1;
            end
            count_q <= count_q + CNT_W'(push_alloc) - CNT_W'(pop);
        end
    end

    assign bus.full_o       = full;
    assign bus.empty_o      = empty;
    assign bus.mem_wen_o    = busy;
    assign bus.mem_awaddr_o = empty ? '0 : {tag_q[head_q], 5'b0};
    assign bus.mem_wdata_o  = empty ? '0 : data_q[head_q];

endmodule

// File: tb/tb_dcache_wb_fifo.sv
// ---------------------------------------------------------------------------
// tb_dcache_wb_fifo
//
// Purpose: self-checking bench for dcache_wb_fifo. A queue-based model of the
// pending victim lines predicts every output each cycle; directed sequences
// cover the basic push/drain, lookup, resend, full/drop/merge and reset
// cases, followed by a randomized phase over a small pool of line addresses.
// Builds with or without WB_FIFO_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_dcache_wb_fifo;

    localparam int DEPTH = 4;

`ifdef WB_FIFO_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
        bit           resend;
    } entry_t;

    logic clk;
    logic rst;

    dcache_wb_fifo_if #(.LINE_W(256), .ADDR_W(32)) bus ();

    dcache_wb_fifo #(.DEPTH(DEPTH), .LINE_W(256), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    entry_t q[$];
    bit     mBusy;
    int     checkCount;
    int     passCount;

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the DUT disagrees.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Returns the queue position holding a line tag, or -1.
    function automatic int findTag(input logic [26:0] t);
        findTag = -1;
        foreach (q[i]) begin
            if (q[i].tag == t) findTag = i;
        end
    endfunction

    // Compares all outputs against the model for the current cycle.
    task automatic checkModel(input logic [31:0] lkaddr);
        int           li;
        logic [255:0] expData;
        bit           expHit;
        li      = findTag(lkaddr[31:5]);
        expHit  = FWD && (li >= 0);
        expData = expHit ? q[li].data : 256'd0;
        checkOutput("mem_wen",  256'(bus.mem_wen_o), 256'(mBusy));
        checkOutput("empty",    256'(bus.empty_o), 256'(q.size() == 0));
        checkOutput("full",     256'(bus.full_o), 256'(q.size() == DEPTH));
        checkOutput("awaddr",   256'(bus.mem_awaddr_o),
                    (q.size() > 0) ? 256'({q[0].tag, 5'b0}) : 256'd0);
        checkOutput("wdata",    bus.mem_wdata_o, (q.size() > 0) ? q[0].data : 256'd0);
        checkOutput("lk_hit",   256'(bus.lookup_hit_o), 256'(expHit));
        checkOutput("lk_data",  bus.lookup_data_o, expData);
    endtask

    // Drives one cycle of inputs at the falling edge, checks the outputs,
    // advances the model by the rules of one rising edge, then waits for
    // the next falling edge.
    task automatic applyStimulus(input bit push, input logic [31:0] waddr,
                                 input logic [255:0] wdata, input logic [31:0] lkaddr,
                                 input bit upd, input logic [31:0] uaddr,
                                 input logic [31:0] uwdata, input bit bvalid);
        entry_t e;
        int     hi;
        int     ui;
        int     preSize;
        bit     wasBusy;
        bit     pop;
        bit     rclr;
        bit     rset;
        bus.wb_req_i      = push;
        bus.wb_addr_i     = waddr;
        bus.wb_data_i     = wdata;
        bus.lookup_addr_i = lkaddr;
        bus.upd_en_i      = upd;
        bus.upd_addr_i    = uaddr;
        bus.upd_wdata_i   = uwdata;
        bus.mem_bvalid_i  = bvalid;
        #1;
        checkModel(lkaddr);

        preSize = q.size();
        wasBusy = mBusy;
        pop     = wasBusy && bvalid && (preSize > 0) && !q[0].resend;
        rclr    = wasBusy && bvalid && (preSize > 0) && q[0].resend;
        rset    = 1'b0;
        if (push) begin
            hi = findTag(waddr[31:5]);
            if (hi >= 0) begin
                e = q[hi];
                e.data = wdata;
                q[hi] = e;
                if (wasBusy && hi == 0) rset = 1'b1;
            end else if (preSize < DEPTH) begin
                e.tag    = waddr[31:5];
                e.data   = wdata;
                e.resend = 1'b0;
                q.push_back(e);
            end
        end
        if (FWD && upd) begin
            ui = findTag(uaddr[31:5]);
            if (ui >= 0) begin
                e = q[ui];
                e.data[int'(uaddr[4:2]) * 32 +: 32] = uwdata;
                q[ui] = e;
                if (wasBusy && ui == 0) rset = 1'b1;
            end
        end
        if (rclr) begin
            e = q[0];
            e.resend = 1'b0;
            q[0] = e;
        end
        if (rset) begin
            e = q[0];
            e.resend = 1'b1;
            q[0] = e;
        end
        if (pop) void'(q.pop_front());
        mBusy = wasBusy ? !bvalid : (preSize != 0);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'd0, 256'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic pushLine(input logic [31:0] a, input logic [255:0] d);
        applyStimulus(1'b1, a, d, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Waits (bounded) for a write request, checks the line on the bus and
    // acknowledges it.
    task automatic drainOne(input string nm, input logic [31:0] ea,
                            input logic [255:0] ed);
        int w;
        w = 0;
        while (!bus.mem_wen_o && w < 10) begin
            idleCycle();
            w++;
        end
        checkOutput({nm, "_wen"},  256'(bus.mem_wen_o), 256'd1);
        checkOutput({nm, "_addr"}, 256'(bus.mem_awaddr_o), 256'(ea));
        checkOutput({nm, "_data"}, bus.mem_wdata_o, ed);
        applyStimulus(1'b0, 32'd0, 256'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Main sequence: directed scenarios, then randomized traffic.
    initial begin
        logic [255:0] d1;
        logic [255:0] d1u;
        logic [255:0] l1;
        logic [255:0] l2;
        logic [255:0] l3;
        logic [255:0] l3m;
        logic [255:0] l4;

        checkCount = 0;
        passCount  = 0;
        mBusy      = 1'b0;
        rst        = 1'b0;
        bus.wb_req_i      = 1'b0;
        bus.wb_addr_i     = '0;
        bus.wb_data_i     = '0;
        bus.lookup_addr_i = '0;
        bus.upd_en_i      = 1'b0;
        bus.upd_addr_i    = '0;
        bus.upd_wdata_i   = '0;
        bus.mem_bvalid_i  = 1'b0;

        d1  = 256'h12345678_91023456_78910234_56789102_34567891_02345678_91023456_78910234;
        d1u = 256'h12345678_91023456_78910234_22222222_34567891_02345678_91023456_78910234;

        repeat (2) @(negedge clk);
        checkOutput("rst_wen",   256'(bus.mem_wen_o), 256'd0);
        checkOutput("rst_full",  256'(bus.full_o), 256'd0);
        checkOutput("rst_empty", 256'(bus.empty_o), 256'd1);
        checkOutput("rst_addr",  256'(bus.mem_awaddr_o), 256'd0);
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");

        // Single line: write request two edges after the push.
        pushLine(32'h24687570, d1);
        checkOutput("t1_wen_early", 256'(bus.mem_wen_o), 256'd0);
        idleCycle();
        checkOutput("t1_wen",   256'(bus.mem_wen_o), 256'd1);
        checkOutput("t1_addr",  256'(bus.mem_awaddr_o), 256'h24687560);
        checkOutput("t1_data",  bus.mem_wdata_o, d1);

        // Lookups against the pending line.
        bus.lookup_addr_i = 32'h24687570;
        #1;
        checkOutput("t2_hit",  256'(bus.lookup_hit_o), 256'(FWD));
        checkOutput("t2_data", bus.lookup_data_o, FWD ? d1 : 256'd0);
        bus.lookup_addr_i = 32'h59687570;
        #1;
        checkOutput("t2_miss_hit",  256'(bus.lookup_hit_o), 256'd0);
        checkOutput("t2_miss_data", bus.lookup_data_o, 256'd0);

        // Modify the line while it is on the bus: word update when
        // forwarding exists, otherwise a merging push of the same content.
        applyStimulus(!FWD, 32'h24687570, d1u, 32'd0, FWD, 32'h24687570,
                      32'h22222222, 1'b0);
        applyStimulus(1'b0, 32'd0, 256'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("t3_gap_wen",   256'(bus.mem_wen_o), 256'd0);
        checkOutput("t3_gap_empty", 256'(bus.empty_o), 256'd0);
        idleCycle();
        checkOutput("t3_resend_wen",  256'(bus.mem_wen_o), 256'd1);
        checkOutput("t3_resend_data", bus.mem_wdata_o, d1u);
        applyStimulus(1'b0, 32'd0, 256'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("t3_empty", 256'(bus.empty_o), 256'd1);
        idleCycle();

        // Fill, drop, merge, then pop with a simultaneous dropped push.
        l1 = randLine(); l2 = randLine(); l3 = randLine(); l4 = randLine();
        l3m = randLine();
        pushLine(32'h100, l1);
        pushLine(32'h200, l2);
        pushLine(32'h300, l3);
        pushLine(32'h400, l4);
        checkOutput("t4_full", 256'(bus.full_o), 256'd1);
        pushLine(32'h500, randLine());
        pushLine(32'h300, l3m);
        checkOutput("t4_full_after", 256'(bus.full_o), 256'd1);
        checkOutput("t5_head_addr", 256'(bus.mem_awaddr_o), 256'h100);
        checkOutput("t5_head_wen",  256'(bus.mem_wen_o), 256'd1);
        applyStimulus(1'b1, 32'h500, randLine(), 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("t5_not_full", 256'(bus.full_o), 256'd0);
        drainOne("t4_line2", 32'h200, l2);
        drainOne("t4_line3", 32'h300, l3m);
        drainOne("t4_line4", 32'h400, l4);
        idleCycle();
        checkOutput("t4_empty", 256'(bus.empty_o), 256'd1);

        // Reset while a line is on the bus.
        pushLine(32'h600, randLine());
        idleCycle();
        checkOutput("t6_wen_before", 256'(bus.mem_wen_o), 256'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_wen",   256'(bus.mem_wen_o), 256'd0);
        checkOutput("t6_empty", 256'(bus.empty_o), 256'd1);
        q.delete();
        mBusy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idleCycle();

        // Randomized traffic over six line addresses to force merges,
        // resends, full drops and simultaneous push/pop.
        for (int c = 0; c < 1500; c++) begin
            logic [31:0] wa;
            logic [31:0] la;
            logic [31:0] ua;
            wa = 32'h4000_0000 + (32'($urandom_range(0, 5)) << 5) + 32'($urandom_range(0, 31));
            la = 32'h4000_0000 + (32'($urandom_range(0, 6)) << 5) + 32'($urandom_range(0, 31));
            ua = 32'h4000_0000 + (32'($urandom_range(0, 6)) << 5) + 32'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 9) < 4, wa, randLine(), la,
                          $urandom_range(0, 9) < 3, ua, $urandom,
                          $urandom_range(0, 9) < 3);
        end
        idleCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
